// File: rtl/gray_code_counter_if.sv
// Control and count bus for gray_code_counter.
// The dir signal exists only when GRAY_CNT_UPDOWN_EN is defined.
interface gray_code_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             clr;
`ifdef GRAY_CNT_UPDOWN_EN
   logic             dir;
`endif
   logic [WIDTH-1:0] binary;
   logic [WIDTH-1:0] gray;
   logic             wrap;

   // Counter user: drives controls, observes the count
   modport master (
`ifdef GRAY_CNT_UPDOWN_EN
      output dir,
`endif
      output en,
      output clr,
      input  binary,
      input  gray,
      input  wrap
   );

   // Counter itself: samples controls, drives the count
   modport slave (
`ifdef GRAY_CNT_UPDOWN_EN
      input  dir,
`endif
      input  en,
      input  clr,
      output binary,
      output gray,
      output wrap
   );
endinterface

// File: rtl/gray_code_counter.sv
// Free-running Gray-code counter: registers a binary count, its Gray encoding
// and a one-cycle wrap pulse. Gray is encoded from the next count so it is
// never combinationally derived at the output.
// Optional macro GRAY_CNT_UPDOWN_EN adds an up/down direction input (dir).
module gray_code_counter #(
   parameter int unsigned WIDTH = 4
) (
   input logic                 clk,
   input logic                 rst,
   gray_code_counter_if.slave  bus
);
   localparam int unsigned W = WIDTH;

   logic [W-1:0] b;
   logic [W-1:0] g;
   logic         wrap_q;

   logic         up_c;
   logic [W-1:0] nb_c;
   logic [W-1:0] ng_c;
   logic         nwrap_c;

   // Direction select: fixed up unless the up/down option is built in
`ifdef GRAY_CNT_UPDOWN_EN
   assign up_c = bus.dir;
`else
   assign up_c = 1'b1;
`endif

   // Next count, its Gray code and boundary-crossing detect
   always_comb begin
      nb_c    = b;
      ng_c    = g;
      nwrap_c = 1'b0;
      if (up_c) begin
         nb_c    = W'(b + W'(1));
         nwrap_c = (b == {W{1'b1}});
      end else begin
         nb_c    = W'(b - W'(1));
         nwrap_c = (b == {W{1'b0}});
      end
      ng_c = nb_c ^ (nb_c >> 1);
   end

   // Count registers: rst > clr > en; wrap pulses only on a wrapping step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b      <= '0;
         g      <= '0;
         wrap_q <= 1'b0;
      end else if (bus.clr) begin
         b      <= '0;
         g      <= '0;
         wrap_q <= 1'b0;
      end else if (bus.en) begin
         b      <= nb_c;
         g      <= ng_c;
         wrap_q <= nwrap_c;
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign bus.binary = b;
   assign bus.gray   = g;
   assign bus.wrap   = wrap_q;
endmodule

// File: doc/gray_code_counter.md
# gray_code_counter

Free-running Gray-code counter that is the encode-side companion to the team's combinational Gray-to-binary converter. It keeps a binary count and registers both the count and its Gray encoding. Consecutive `gray` values therefore differ in exactly one bit and are glitch-free. Intended use is as a pointer source for clock-domain-crossing structures (async FIFO write/read pointers), where the far side decodes with the Gray-to-binary converter.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits, minimum 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  advance count by one step this cycle.
- `clr`  input  1  synchronous clear to zero.
- `dir`  input  1  count direction, 1 = up, 0 = down. Present only with `GRAY_CNT_UPDOWN_EN`.
- `binary`  output  WIDTH  registered binary count.
- `gray`  output  WIDTH  registered Gray code of `binary`.
- `wrap`  output  1  registered one-cycle pulse on count wrap-around.

## Operation
- State:
  - binary register `b`.
  - Gray register `g`.
  - `wrap` flop.
  - No other state.
- Next-count computation, applied on every edge where `en`=1:
  - Up: nb = (b + 1) mod 2^WIDTH.
  - Down: nb = (b − 1) mod 2^WIDTH.
  - The carry/borrow bit is discarded.
- `g` is loaded from nb ^ (nb >> 1), a logical shift with MSB fill 0.
  - The encode uses the next value, not the current one. This keeps `g` registered and never combinationally derived from `b` at the output.
  - Invariant: `gray` == `binary` ^ (`binary` >> 1) in every cycle after reset.
- Priority, highest first: `rst` > `clr` > `en`.
  - `clr`=1: `b` and `g` ← 0 and `wrap` ← 0, regardless of `en`/`dir`.
  - `en`=0 and `clr`=0: `b` and `g` hold, and `wrap` ← 0.
- `wrap` ← 1 only on an `en` step that crosses a boundary:
  - Up: from all-ones to zero.
  - Down: from zero to all-ones.
  - Every other step sets `wrap` ← 0.
- Reset mid-count: `rst` forces all registers to zero immediately, with no clock needed. Counting resumes from 0 on the first edge where `en`=1 after `rst` deasserts.
- `dir` may change on any cycle. It is sampled only on edges where `en`=1.

## Timing
- Reset values: `binary`=0, `gray`=0, `wrap`=0.
- Latency: outputs reflect a step 1 cycle after the edge that sampled `en`=1. Nothing is combinational from input to output.
- Throughput: one step per cycle when `en` is held high.
- Between any two consecutive clock edges with `en`=1 and `clr`=0, `gray` changes in exactly one bit position.
- Exception: `clr` or `rst` may change multiple bits of `gray` at once. Consumers in other domains must not sample across a clear.
- `wrap` is high for exactly the one cycle in which the wrapped value is presented on `binary`/`gray`.

## Configuration
- Macro: `GRAY_CNT_UPDOWN_EN`.
- Defined: the `dir` port exists and the counter counts up or down per `dir`. Down wrap (0 → all-ones) asserts `wrap`.
- Undefined:
  - The `dir` port is absent.
  - The counter counts up only; behaviour is identical to the defined build with `dir` tied to 1.

## Test plan
All scenarios use `WIDTH`=4.
- Reset:
  - Stimulus: assert `rst` with no clock running.
  - Required: `binary`=0000, `gray`=0000, `wrap`=0 immediately. The first `en` edge after release gives `binary`=0001, `gray`=0001.
- Full up cycle:
  - Stimulus: hold `en`=1 for 16 cycles.
  - Required: `gray` steps 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
  - Required: a checker confirms exactly one bit changes per step. `wrap`=1 only in the cycle `binary` returns to 0000.
- Hold:
  - Stimulus: at `binary`=0101 (`gray`=0111), drop `en` for 3 cycles.
  - Required: both outputs hold and `wrap`=0. Re-asserting `en` gives `binary`=0110, `gray`=0101.
- Clear vs enable:
  - Stimulus: at `binary`=1010, assert `clr`=1 together with `en`=1.
  - Required: next cycle `binary`=0000, `gray`=0000, `wrap`=0.
- Async reset mid-count:
  - Stimulus: at `binary`=0111, pulse `rst` between clock edges.
  - Required: outputs go to 0 before the next edge and resume counting from 0001.
- Down mode (`GRAY_CNT_UPDOWN_EN` defined):
  - Stimulus: from 0, `dir`=0, `en`=1.
  - Required: next cycle `binary`=1111, `gray`=1000, `wrap`=1. The following cycle gives `binary`=1110, `gray`=1001, `wrap`=0.
